// File: rtl/ysyx_22051013_shift_divider.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their W forms.
// Latency: out_valid N+1 cycles after accept (N=64, or 32 for W forms); 1 cycle for divide-by-zero.
// Backpressure: none. div_valid is sampled only when idle and is dropped otherwise; flush aborts.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   div_valid              request strobe (accepted only in IDLE)
//   flush                  abort any in-flight operation, result registers untouched
//   div_signed, divw       signed select, 32-bit (W) operation select
//   div_op1, div_op2       dividend, divisor (captured on the accept cycle)
//   out_valid              one-cycle result strobe
//   quotient, remainder    registered results, held until the next load
module ysyx_22051013_shift_divider #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            div_valid,
    input  logic            flush,
    input  logic            div_signed,
    input  logic            divw,
    input  logic [XLEN-1:0] div_op1,
    input  logic [XLEN-1:0] div_op2,
    output logic            out_valid,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int HLEN = XLEN / 2;
    localparam int CW   = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    // Partial remainder. The algorithm needs 65 bits only transiently (after
    // the shift, before the compare); once the conditional subtract is done
    // the value is always below the divisor, so 64 bits are stored.
    logic [XLEN-1:0]   r_pr;
    logic [XLEN-1:0]   r_dvd;
    logic [XLEN-1:0]   r_dvs;
    logic [XLEN-1:0]   r_q;
    logic              r_q_neg;
    logic              r_r_neg;
    logic              r_w;
    logic [XLEN-1:0]   r_quotient;
    logic [XLEN-1:0]   r_remainder;

    // ------------------------------------------------------------------
    // Operand preparation (accept cycle)
    // ------------------------------------------------------------------
    logic              w_a_sgn;
    logic              w_b_sgn;
    logic [HLEN-1:0]   w_a_lo;
    logic [HLEN-1:0]   w_b_lo;
    logic [HLEN-1:0]   w_a_abs_lo;
    logic [HLEN-1:0]   w_b_abs_lo;
    logic [XLEN-1:0]   w_a_abs_full;
    logic [XLEN-1:0]   w_b_abs_full;
    logic [XLEN-1:0]   w_dvd_init;
    logic [XLEN-1:0]   w_dvs_init;
    logic              w_dvs_zero;
    logic [XLEN-1:0]   w_op1_sext;

    assign w_a_sgn = div_signed & (divw ? div_op1[HLEN-1] : div_op1[XLEN-1]);
    assign w_b_sgn = div_signed & (divw ? div_op2[HLEN-1] : div_op2[XLEN-1]);

    assign w_a_lo = div_op1[HLEN-1:0];
    assign w_b_lo = div_op2[HLEN-1:0];

    // Magnitudes. The most-negative value negates to itself, which read as
    // unsigned is exactly 2^(n-1), so MIN / -1 falls out with no special case.
    assign w_a_abs_lo   = w_a_sgn ? (~w_a_lo + 1'b1) : w_a_lo;
    assign w_b_abs_lo   = w_b_sgn ? (~w_b_lo + 1'b1) : w_b_lo;
    assign w_a_abs_full = w_a_sgn ? (~div_op1 + 1'b1) : div_op1;
    assign w_b_abs_full = w_b_sgn ? (~div_op2 + 1'b1) : div_op2;

    // W-form dividend is parked in the upper half so the iteration always
    // pulls the next bit from the top of r_dvd, regardless of width.
    assign w_dvd_init = divw ? {w_a_abs_lo, {HLEN{1'b0}}} : w_a_abs_full;
    assign w_dvs_init = divw ? {{HLEN{1'b0}}, w_b_abs_lo} : w_b_abs_full;

    assign w_dvs_zero = divw ? (w_b_lo == '0) : (div_op2 == '0);
    assign w_op1_sext = {{HLEN{w_a_lo[HLEN-1]}}, w_a_lo};

    // ------------------------------------------------------------------
    // One restoring step
    // ------------------------------------------------------------------
    logic [XLEN:0]     w_pr_shift;
    logic              w_ge;
    logic [XLEN-1:0]   w_pr_next;
    logic [XLEN-1:0]   w_q_next;

    assign w_pr_shift = {r_pr, r_dvd[XLEN-1]};
    assign w_ge       = (w_pr_shift >= {1'b0, r_dvs});
    // When w_ge holds, the difference is below the divisor and so fits in
    // XLEN bits; the wrapped low-half subtraction is therefore exact.
    assign w_pr_next  = w_ge ? (w_pr_shift[XLEN-1:0] - r_dvs) : w_pr_shift[XLEN-1:0];
    assign w_q_next   = {r_q[XLEN-2:0], w_ge};

    // ------------------------------------------------------------------
    // Final sign fix-up, evaluated on the last iteration
    // ------------------------------------------------------------------
    logic [XLEN-1:0]   w_q_fix;
    logic [XLEN-1:0]   w_r_fix;
    logic [XLEN-1:0]   w_q_res;
    logic [XLEN-1:0]   w_r_res;

    assign w_q_fix = r_q_neg ? (~w_q_next + 1'b1) : w_q_next;
    assign w_r_fix = r_r_neg ? (~w_pr_next + 1'b1) : w_pr_next;

    // W forms (including the unsigned ones) sign-extend from bit HLEN-1.
    assign w_q_res = r_w ? {{HLEN{w_q_fix[HLEN-1]}}, w_q_fix[HLEN-1:0]} : w_q_fix;
    assign w_r_res = r_w ? {{HLEN{w_r_fix[HLEN-1]}}, w_r_fix[HLEN-1:0]} : w_r_fix;

    // ------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_pr        <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_q         <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_w         <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else if (flush) begin
            // Abort only; the result registers keep whatever was last loaded.
            r_state <= S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (div_valid) begin
                        if (w_dvs_zero) begin
                            r_quotient  <= '1;
                            r_remainder <= divw ? w_op1_sext : div_op1;
                            r_state     <= S_DONE;
                        end else begin
                            r_dvd   <= w_dvd_init;
                            r_dvs   <= w_dvs_init;
                            r_pr    <= '0;
                            r_q     <= '0;
                            r_q_neg <= w_a_sgn ^ w_b_sgn;
                            r_r_neg <= w_a_sgn;
                            r_w     <= divw;
                            r_cnt   <= divw ? CW'(HLEN) : CW'(XLEN);
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_pr  <= w_pr_next;
                    r_dvd <= {r_dvd[XLEN-2:0], 1'b0};
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_quotient  <= w_q_res;
                        r_remainder <= w_r_res;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign out_valid = (r_state == S_DONE);
    assign quotient  = r_quotient;
    assign remainder = r_remainder;

endmodule

// File: tb/tb_ysyx_22051013_shift_divider.sv
// Bench for ysyx_22051013_shift_divider: arithmetic reference model with a per-cycle
// compare process, plus directed vectors carrying hand-computed expectations.
// Inputs are driven 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_ysyx_22051013_shift_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        div_valid = 1'b0;
    logic        flush = 1'b0;
    logic        div_signed = 1'b0;
    logic        divw = 1'b0;
    logic [63:0] div_op1 = '0;
    logic [63:0] div_op2 = '0;
    logic        out_valid;
    logic [63:0] quotient;
    logic [63:0] remainder;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    ysyx_22051013_shift_divider #(.XLEN(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_valid  (div_valid),
        .flush      (flush),
        .div_signed (div_signed),
        .divw       (divw),
        .div_op1    (div_op1),
        .div_op2    (div_op2),
        .out_valid  (out_valid),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // RISC-V M-extension semantics from plain arithmetic; lat is the number
    // of cycles from the accept cycle to the out_valid cycle.
    task automatic model(input logic [63:0] a, input logic [63:0] b, input logic s,
                         input logic w, output logic [63:0] q, output logic [63:0] r,
                         output int lat);
        logic [31:0] a32, b32, q32, r32;
        a32 = a[31:0];
        b32 = b[31:0];
        if (w) begin
            if (b32 == 32'd0) begin
                q32 = '1; r32 = a32; lat = 1;
            end else begin
                lat = 33;
                if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                    q32 = a32; r32 = '0;
                end else if (s) begin
                    q32 = $signed(a32) / $signed(b32);
                    r32 = $signed(a32) % $signed(b32);
                end else begin
                    q32 = a32 / b32;
                    r32 = a32 % b32;
                end
            end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            if (b == 64'd0) begin
                q = '1; r = a; lat = 1;
            end else begin
                lat = 65;
                if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
                    q = a; r = '0;
                end else if (s) begin
                    q = $signed(a) / $signed(b);
                    r = $signed(a) % $signed(b);
                end else begin
                    q = a / b;
                    r = a % b;
                end
            end
        end
    endtask

    // Per-cycle compare against the model: one pending result at most,
    // due at an absolute cycle; results are held until the next one lands.
    logic        m_pend = 1'b0;
    int          m_due  = 0;
    logic [63:0] m_pq = '0, m_pr = '0;
    logic [63:0] m_hq = '0, m_hr = '0;

    always @(negedge clk) begin
        logic        exp_out, idle;
        logic [63:0] nq, nr;
        int          lat;
        exp_out = m_pend && (cyc == m_due);
        if (exp_out) begin
            m_hq = m_pq;
            m_hr = m_pr;
        end
        chk("out_valid", {63'd0, out_valid}, {63'd0, exp_out});
        chk("quotient", quotient, m_hq);
        chk("remainder", remainder, m_hr);
        idle = !m_pend;
        if (exp_out) m_pend = 1'b0;
        if (rst) begin
            m_pend = 1'b0;
            m_hq = '0;
            m_hr = '0;
        end else if (flush) begin
            m_pend = 1'b0;
        end else if (idle && div_valid) begin
            model(div_op1, div_op2, div_signed, divw, nq, nr, lat);
            m_pq = nq;
            m_pr = nr;
            m_due = cyc + lat;
            m_pend = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic s, input logic w);
        div_valid = 1'b1; div_op1 = a; div_op2 = b; div_signed = s; divw = w;
        tick();
        div_valid = 1'b0;
    endtask

    // Issue one request and check the hand-computed result in its out_valid cycle.
    task automatic run_lit(input string name, input logic [63:0] a, input logic [63:0] b,
                           input logic s, input logic w, input int lat,
                           input logic [63:0] eq, input logic [63:0] er);
        issue(a, b, s, w);
        repeat (lat - 1) tick();
        chk({name, ".out_valid"}, {63'd0, out_valid}, 64'd1);
        chk({name, ".q"}, quotient, eq);
        chk({name, ".r"}, remainder, er);
        tick();
    endtask

    initial begin
        logic [63:0] pq, pr;
        int          pl;

        // Pin the reference model on a few hand-worked cases.
        model(64'd100, 64'd7, 1'b0, 1'b0, pq, pr, pl);
        chk("model.divu.q", pq, 64'd14);
        chk("model.divu.r", pr, 64'd2);
        chk("model.divu.lat", 64'(pl), 64'd65);
        model(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, pq, pr, pl);
        chk("model.div.q", pq, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("model.div.r", pr, 64'hFFFF_FFFF_FFFF_FFFF);
        model(64'h0000_0000_8000_0000, '1, 1'b1, 1'b1, pq, pr, pl);
        chk("model.divw_ovf.q", pq, 64'hFFFF_FFFF_8000_0000);
        chk("model.divw_ovf.lat", 64'(pl), 64'd33);

        repeat (3) tick();
        chk("reset.out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset.q", quotient, 64'd0);
        chk("reset.r", remainder, 64'd0);
        rst = 1'b0;
        tick();

        run_lit("divu64", 64'd100, 64'd7, 1'b0, 1'b0, 65, 64'd14, 64'd2);
        run_lit("div_neg", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 65,
                64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF);
        run_lit("divw_ovf", 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 33,
                64'hFFFF_FFFF_8000_0000, 64'd0);
        run_lit("div0", 64'd5, 64'd0, 1'b1, 1'b0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5);
        run_lit("divuw0", 64'h1_FFFF_FFFE, 64'h1_0000_0000, 1'b0, 1'b1, 1,
                64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE);
        run_lit("divuw_sext", 64'hFFFF_FFFE, 64'd1, 1'b0, 1'b1, 33,
                64'hFFFF_FFFF_FFFF_FFFE, 64'd0);
        run_lit("div64_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 65,
                64'h8000_0000_0000_0000, 64'd0);
        run_lit("div_negneg", 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 1'b0, 65,
                64'd14, 64'hFFFF_FFFF_FFFF_FFFE);
        run_lit("remw_neg", 64'h0000_0000_FFFF_FFF9, 64'd3, 1'b1, 1'b1, 33,
                64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF);

        // Flush at cycle 10 with ignored requests in cycles 2..9, then 100/7 at cycle 12.
        issue(64'd1000, 64'd3, 1'b0, 1'b0);
        for (int k = 1; k < 77; k++) begin
            div_valid  = (k >= 2 && k <= 9) || (k == 12);
            div_op1    = (k == 12) ? 64'd100 : 64'd5;
            div_op2    = (k == 12) ? 64'd7 : 64'd0;
            div_signed = 1'b0;
            divw       = 1'b0;
            flush      = (k == 10);
            tick();
            if (k == 11) chk("flush.no_out", {63'd0, out_valid}, 64'd0);
        end
        div_valid = 1'b0;
        flush = 1'b0;
        chk("after_flush.out_valid", {63'd0, out_valid}, 64'd1);
        chk("after_flush.q", quotient, 64'd14);
        chk("after_flush.r", remainder, 64'd2);
        tick();

        // Flush beats div_valid in the same idle cycle.
        div_valid = 1'b1; flush = 1'b1; div_op1 = 64'd9; div_op2 = 64'd0;
        repeat (3) tick();
        div_valid = 1'b0; flush = 1'b0;
        tick();
        chk("flush_prio.out_valid", {63'd0, out_valid}, 64'd0);

        // Reset mid-calculation discards the operation and clears the results.
        issue(64'd12345, 64'd11, 1'b0, 1'b0);
        repeat (20) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid.out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_mid.q", quotient, 64'd0);
        chk("rst_mid.r", remainder, 64'd0);
        repeat (70) tick();

        run_lit("post_rst", 64'd12345, 64'd11, 1'b0, 1'b0, 65, 64'd1122, 64'd3);
        repeat (2) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ysyx_22051013_shift_divider.md
# ysyx_22051013_shift_divider

Iterative radix-2 restoring divider serving as the responder side of the EXU divide handshake (`div_valid` / `out_valid`). It accepts one request, computes quotient and remainder one bit per cycle, and returns both with a single-cycle `out_valid` pulse. It covers RV64M DIV/DIVU/REM/REMU and the 32-bit W forms. Operands must be held stable by the EXU only for the accept cycle, because the divider captures them internally.

## Interface
- `XLEN`, 64, datapath width. Fixed: W forms use `XLEN/2`.
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `div_valid` input 1: request strobe. Sampled only in IDLE.
- `flush` input 1: aborts any in-flight operation.
- `div_signed` input 1: 1 selects signed (DIV/REM/DIVW/REMW); 0 selects unsigned.
- `divw` input 1: 1 selects 32-bit operation on `op[31:0]`, with the result sign-extended.
- `div_op1` input 64: dividend.
- `div_op2` input 64: divisor.
- `out_valid` output 1: one-cycle result strobe.
- `quotient` output 64: registered quotient.
- `remainder` output 64: registered remainder.

## Operation
- States: IDLE, CALC, DONE.
- **IDLE**
  - `div_valid`=1, no flush, divisor (masked to 32 bits if `divw`) equals 0: load `quotient`=all-ones and `remainder`=dividend. For `divw`, `remainder` = sign-extended `op1[31:0]`. Go to DONE.
  - `div_valid`=1, no flush, divisor ≠ 0: capture the operands, then go to CALC with counter N (64, or 32 if `divw`).
    - Capture values: |dividend|, |divisor| (absolute value only when `div_signed`; sign taken from bit 63 or bit 31), `q_neg` = sa^sb, `r_neg` = sa.
    - 65-bit partial remainder cleared.
- **CALC**, per cycle:
  - `pr = {pr[63:0], dvd_msb}`; shift the dividend left.
  - If `pr >= divisor`: `pr -= divisor` and quotient bit = 1; otherwise quotient bit = 0.
  - Counter decrements. At the last iteration, register the final results and go to DONE:
    - `quotient` = `q_neg` ? −q : q.
    - `remainder` = `r_neg` ? −r : r.
    - If `divw`, both results are sign-extended from bit 31. DIVUW/REMUW are sign-extended as well.
- **DONE**: `out_valid`=1 for exactly this cycle, then go to IDLE.
- **Signed overflow** (most-negative / −1) needs no special path:
  - |MIN| = 2^(n−1) as unsigned, which yields quotient = MIN and remainder = 0.
- **Holding results**: `quotient` and `remainder` hold their value after DONE until the next load. The EXU latches them on `out_valid`.
- **`div_valid` while in CALC or DONE**: ignored (not queued).
- **`flush` in any state**: next state is IDLE. `out_valid` stays 0 on the next cycle. Result registers are unchanged. `flush` has priority over `div_valid` in the same cycle.

## Timing
- Cycle 0 is the IDLE cycle with `div_valid`=1.
  - Normal case: CALC occupies cycles 1..N and `out_valid`=1 in cycle N+1. This is cycle 65 for 64-bit and cycle 33 for W.
  - Divide-by-zero: `out_valid`=1 in cycle 1.
- Earliest next accept: cycle N+2, or cycle 2 after divide-by-zero.
- `out_valid` decodes directly from the state register, with no combinational path from inputs.
- Reset values: state=IDLE, `out_valid`=0, `quotient`=0, `remainder`=0, counter=0.
- Reset mid-CALC discards the operation; no `out_valid` is produced.
- Reset has priority over `flush` and over `div_valid`.

## Test plan
- **DIVU 64-bit**: op1=100, op2=7, signed=0, w=0 → `out_valid` at cycle 65 only; quotient=14, remainder=2.
- **DIV negative**: op1=−7, op2=2, signed=1 → quotient=0xFFFF_FFFF_FFFF_FFFD (−3), remainder=0xFFFF_FFFF_FFFF_FFFF (−1) at cycle 65.
- **DIVW overflow**: op1=0x0000_0000_8000_0000, op2=0xFFFF_FFFF_FFFF_FFFF, signed=1, w=1 → `out_valid` at cycle 33; quotient=0xFFFF_FFFF_8000_0000, remainder=0.
- **Divide-by-zero**: op1=5, op2=0, signed=1 → `out_valid` at cycle 1; quotient=all-ones, remainder=5. DIVUW with op1=0x1_FFFF_FFFE, op2=0x1_0000_0000 → cycle 1, remainder=0xFFFF_FFFF_FFFF_FFFE.
- **DIVUW sign-extension**: op1=0xFFFF_FFFE, op2=1, signed=0, w=1 → quotient=0xFFFF_FFFF_FFFF_FFFE, remainder=0 at cycle 33.
- **Flush, busy-ignore and reset**:
  - `flush` at cycle 10 of a 64-bit op, plus `div_valid` pulses during cycles 2–9 → no `out_valid` ever for that op.
  - A new request (100/7) at cycle 12 → `out_valid` at cycle 77 with 14/2.
  - `rst` mid-CALC → outputs return to 0 and no `out_valid`.
